multicycle_controller: RTL
==========================

# multicycle_controller

Main control FSM that sequences the shared multicycle datapath (single ALU, single unified memory port, PC/IR/OldPC/A/ALUOut/Data registers) for the RV32I subset lw, sw, R-type ALU, I-type ALU, beq, jal. Decodes the opcode once per instruction and steps the datapath through its Fetch/Decode/Execute/Writeback cycles. Emits every mux select, register enable and ALU control. Stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- op  in  7  Instr[6:0], from IR
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=A
- ALUSrcB  out  2  00=WriteData, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- Illegal  out  1  one-cycle pulse in Decode for an unsupported opcode
- State  out  4  current state encoding (debug)

## Operation
- State encodings: Fetch 0, Decode 1, MemAdr 2, MemRead 3, MemWB 4, MemWrite 5, ExecuteR 6, ALUWB 7, ExecuteI 8, JAL 9, BEQ 10. Encodings 11–15 go to Fetch on the next edge, with all enables 0.
- Outputs are Moore (a function of state only), except where Zero or MemReady is noted. Any output not listed for a state is 0 / 00 / 000.
- Fetch: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = MemReady.
  - Next state: Decode if MemReady, else stay in Fetch.
- Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MemAdr
  - 0110011 → ExecuteR
  - 0010011 → ExecuteI
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else → Fetch, with Illegal=1
- MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MemRead if op=0000011, else MemWrite.
- MemRead: AdrSrc=1, ResultSrc=00. Next: MemWB if MemReady, else stay.
- MemWB: ResultSrc=01, RegWrite=1. Next: Fetch.
- MemWrite: AdrSrc=1, ResultSrc=00, MemWrite=1; MemWrite is held until MemReady. Next: Fetch if MemReady, else stay.
- ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: Fetch.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: Fetch.
- Internal signals:
  - PCWrite = PCUpdate | (Branch & Zero).
  - ALU decoder:
    - ALUOp 00 → 000; ALUOp 01 → 001.
    - ALUOp 10, funct3 000 → 001 if (op[5] & funct7b5), else 000.
    - ALUOp 10, funct3 010 → 101; 110 → 011; 111 → 010; any other funct3 → 000.
  - ImmSrc is decoded combinationally from op in every state:
    - 0100011 → 01; 1100011 → 10; 1101111 → 11; otherwise 00.

## Timing
- Reset: while rst=0, state=Fetch, and PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced to 0. All selects take their Fetch values and State=0.
- Reset asserted mid-instruction: the FSM returns to Fetch immediately (asynchronously), with no write enable asserted.
- The first rising edge after reset release with MemReady=1 performs the fetch.
- Cycle counts with MemReady tied to 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle MemReady is low in Fetch, MemRead or MemWrite adds exactly one cycle; selects stay stable throughout the stall.
- MemReady is ignored in every other state.

## Test plan
- Reset and fetch: hold rst=0 for 3 cycles, then release with MemReady=1 → State 0, no enables asserted during reset. Next edge: IRWrite=PCWrite=1 in Fetch, State→1.
- lw sequence, op=0000011, with MemReady=0 for 2 cycles in MemRead → states 0,1,2,3,3,3,4,0. In MemWB: RegWrite=1, ResultSrc=01. ImmSrc=00 throughout.
- R-type sub, op=0110011, funct3=000, funct7b5=1 → ExecuteR with ALUControl=001, then ALUWB with RegWrite=1. Repeat with funct3=010 → ALUControl=101.
- beq, op=1100011: Zero=1 → PCWrite=1 in BEQ; Zero=0 → PCWrite=0. Both cases: 3 cycles, ALUControl=001, ImmSrc=10.
- sw with MemReady low for 1 cycle in MemWrite → MemWrite=1 for 2 consecutive cycles, AdrSrc=1, then Fetch.
- Illegal and mid-instruction reset:
  - op=1111111 → Illegal=1 for exactly 1 cycle in Decode, then Fetch.
  - rst=0 asserted mid-cycle during MemWB → RegWrite drops immediately and State=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// Instruction fields, ALU zero and memory ready flow into the controller;
// every select, enable and ALU control flows out to the datapath.
//
// Handshake: MemReady is driven by memory and means "the access presented this
// cycle completes at the next rising edge". The controller holds AdrSrc,
// MemWrite and all other selects stable for as long as MemReady stays low in
// Fetch, MemRead or MemWrite. MemReady is ignored in every other state.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       Illegal;
    logic [3:0] State;

    // Controller side
    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
        output Illegal, State
    );

    // Datapath / memory side
    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
        input  Illegal, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM for the RV32I-subset multicycle datapath (lw, sw, R-type,
// I-type, beq, jal). Moore outputs from the state, except the Fetch enables
// (gated by MemReady) and PCWrite in BEQ (gated by Zero). Write enables are
// forced low while rst is held low.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master ctrl
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECUTER  = 4'd6,
        S_ALUWB     = 4'd7,
        S_EXECUTEI  = 4'd8,
        S_JAL       = 4'd9,
        S_BEQ       = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_q, state_d;

    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic [2:0] alu_control;

    // State register; reset returns to Fetch immediately, mid-instruction or not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_d    = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;

        case (state_q)
            S_FETCH: begin
                // PC + 4 goes straight back into PC via ALUResult
                adr_src    = 1'b0;
                alu_src_a  = 2'b00;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b10;
                ir_write   = ctrl.MemReady;
                pc_update  = ctrl.MemReady;
                state_d    = ctrl.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // OldPC + imm: branch/jump target parked in ALUOut
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                state_d   = (ctrl.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = 2'b00;
                state_d    = ctrl.MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe held until memory accepts the store
                adr_src    = 1'b1;
                result_src = 2'b00;
                mem_write  = 1'b1;
                state_d    = ctrl.MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_JAL: begin
                // OldPC + 4 computed for rd while ALUOut (target) loads the PC
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b00;
                pc_update  = 1'b1;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = 2'b01;
                result_src = 2'b00;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Unused encodings recover to Fetch with everything idle
                state_d = S_FETCH;
            end
        endcase
    end

    // ALU decoder: funct7b5 only means subtract for register-register ops
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b00: alu_control = 3'b000;
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (ctrl.funct3)
                    3'b000:  alu_control = (ctrl.op[5] & ctrl.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // Immediate format, decoded from the opcode in every state
    always_comb begin
        imm_src = 2'b00;
        case (ctrl.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Enables are gated by rst so nothing writes while reset is held,
    // even though Fetch's MemReady-driven enables would otherwise fire
    assign ctrl.PCWrite    = rst & (pc_update | (branch & ctrl.Zero));
    assign ctrl.IRWrite    = rst & ir_write;
    assign ctrl.MemWrite   = rst & mem_write;
    assign ctrl.RegWrite   = rst & reg_write;
    assign ctrl.Illegal    = rst & illegal;
    assign ctrl.AdrSrc     = adr_src;
    assign ctrl.ResultSrc  = result_src;
    assign ctrl.ALUSrcA    = alu_src_a;
    assign ctrl.ALUSrcB    = alu_src_b;
    assign ctrl.ImmSrc     = imm_src;
    assign ctrl.ALUControl = alu_control;
    assign ctrl.State      = state_q;

endmodule
